// File: rtl/tcdm_lfsr_stall_mem.sv
// Multi-port TCDM slave memory with LFSR-driven grant stalls, configurable read
// latency, out-of-range detection and per-port granted-transaction counters.
module tcdm_lfsr_stall_mem #(
  parameter int unsigned NPORTS     = 2,
  parameter int unsigned DEPTH      = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h1C000000,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned STALL_THR  = 128,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter logic [31:0] ERR_DATA   = 32'hBADCAB1E
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          stall_en_i,
  input  logic [NPORTS-1:0]             tcdm_req_i,
  output logic [NPORTS-1:0]             tcdm_gnt_o,
  input  logic [NPORTS-1:0][31:0]       tcdm_add_i,
  input  logic [NPORTS-1:0]             tcdm_wen_i,
  input  logic [NPORTS-1:0][3:0]        tcdm_be_i,
  input  logic [NPORTS-1:0][31:0]       tcdm_data_i,
  output logic [NPORTS-1:0]             tcdm_r_valid_o,
  output logic [NPORTS-1:0][31:0]       tcdm_r_data_o,
  output logic                          err_o,
  output logic [NPORTS-1:0][15:0]       txn_cnt_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam logic [8:0]  THR = 9'(STALL_THR);

  logic [31:0]                          mem_q [DEPTH];
  logic [NPORTS-1:0][15:0]              lfsr_q, lfsr_d;
  logic [NPORTS-1:0][15:0]              txn_cnt_q, txn_cnt_d;
  logic                                 err_q, err_d;
  logic [RD_LATENCY-1:0][NPORTS-1:0]    rsp_vld_q, rsp_vld_d;
  logic [RD_LATENCY-1:0][NPORTS-1:0][31:0] rsp_dat_q, rsp_dat_d;

  logic [NPORTS-1:0][31:0]              off_s;
  logic [NPORTS-1:0][AW-1:0]            idx_s;
  logic [NPORTS-1:0]                    in_range_s;
  logic [NPORTS-1:0]                    gnt_s;
  logic [NPORTS-1:0]                    wr_s;

  function automatic logic [15:0] lfsr_seed(input int unsigned p);
    logic [15:0] s;
    s = SEED ^ 16'(p);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  always_comb begin
    rsp_vld_d = '0;
    rsp_dat_d = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      // 32-bit wrap on underflow lands far above DEPTH, so it decodes out of range
      off_s[p]      = tcdm_add_i[p] - BASE_ADDR;
      in_range_s[p] = (tcdm_add_i[p] >= BASE_ADDR) && ((off_s[p] >> 2) < DEPTH);
      idx_s[p]      = off_s[p][AW+1:2];
      gnt_s[p]      = ~rst_i & tcdm_req_i[p]
                      & ~(stall_en_i & ({1'b0, lfsr_q[p][7:0]} < THR));
      wr_s[p]       = gnt_s[p] & ~tcdm_wen_i[p] & in_range_s[p];
      txn_cnt_d[p]  = txn_cnt_q[p] + 16'(gnt_s[p]);
      lfsr_d[p]     = lfsr_step(lfsr_q[p]);
      rsp_vld_d[0][p] = gnt_s[p];
      if (!gnt_s[p] || !tcdm_wen_i[p]) begin
        rsp_dat_d[0][p] = 32'h0;
      end else if (in_range_s[p]) begin
        rsp_dat_d[0][p] = mem_q[idx_s[p]];
      end else begin
        rsp_dat_d[0][p] = ERR_DATA;
      end
    end
    for (int unsigned s = 1; s < RD_LATENCY; s++) begin
      rsp_vld_d[s] = rsp_vld_q[s-1];
      rsp_dat_d[s] = rsp_dat_q[s-1];
    end
    err_d = err_q | (|(gnt_s & ~in_range_s));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        lfsr_q[p] <= lfsr_seed(p);
      end
      txn_cnt_q <= '0;
      err_q     <= 1'b0;
      rsp_vld_q <= '0;
      rsp_dat_q <= '0;
    end else begin
      lfsr_q    <= lfsr_d;
      txn_cnt_q <= txn_cnt_d;
      err_q     <= err_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

  // Highest port is applied first so the lowest index wins on overlapping bytes
  always_ff @(posedge clk_i) begin
    for (int p = int'(NPORTS) - 1; p >= 0; p--) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_s[p] && tcdm_be_i[p][b]) begin
          mem_q[idx_s[p]][8*b +: 8] <= tcdm_data_i[p][8*b +: 8];
        end
      end
    end
  end

  assign tcdm_gnt_o     = gnt_s;
  assign tcdm_r_valid_o = rsp_vld_q[RD_LATENCY-1];
  assign tcdm_r_data_o  = rsp_dat_q[RD_LATENCY-1];
  assign err_o          = err_q;
  assign txn_cnt_o      = txn_cnt_q;

endmodule

// File: tb/tb_tcdm_lfsr_stall_mem.sv
// Bench for tcdm_lfsr_stall_mem: two differently configured instances share one
// stimulus stream and are compared every cycle against a transaction-level model.
module tb_tcdm_lfsr_stall_mem;

  localparam logic [31:0] BASE = 32'h1C000000;
  localparam logic [31:0] ERRD = 32'hBADCAB1E;
  localparam int LAT_M   [2] = '{1, 3};
  localparam int DEPTH_M [2] = '{1024, 256};
  localparam int THR_M   [2] = '{128, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, stall_en;
  logic [1:0]          req, wen;
  logic [1:0][31:0]    add, wdata;
  logic [1:0][3:0]     be;
  logic [1:0]          gnt_w [2];
  logic [1:0]          rv_w  [2];
  logic [1:0][31:0]    rd_w  [2];
  logic                err_w [2];
  logic [1:0][15:0]    txn_w [2];

  tcdm_lfsr_stall_mem #(.NPORTS(2), .DEPTH(1024), .RD_LATENCY(1), .STALL_THR(128)) dut_a (
    .clk_i(clk), .rst_i(rst), .stall_en_i(stall_en),
    .tcdm_req_i(req), .tcdm_gnt_o(gnt_w[0]), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_valid_o(rv_w[0]), .tcdm_r_data_o(rd_w[0]),
    .err_o(err_w[0]), .txn_cnt_o(txn_w[0]));

  tcdm_lfsr_stall_mem #(.NPORTS(2), .DEPTH(256), .RD_LATENCY(3), .STALL_THR(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .stall_en_i(stall_en),
    .tcdm_req_i(req), .tcdm_gnt_o(gnt_w[1]), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_valid_o(rv_w[1]), .tcdm_r_data_o(rd_w[1]),
    .err_o(err_w[1]), .txn_cnt_o(txn_w[1]));

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] lfsr_m [2][2];
  logic [15:0] txn_m  [2][2];
  bit          err_m  [2];
  logic [7:0]  mem_m  [int];
  int          due_q  [2][2][$];
  logic [31:0] dat_q  [2][2][$];
  bit          kn_q   [2][2][$];
  int          edges = 0;
  bit [1:0]    g_m;
  logic [31:0] rdat_m;
  bit          rkn_m;
  bit          cmp_ev, cmp_ek;
  logic [31:0] cmp_ed;
  int          rv_cnt  [2][2];
  logic [31:0] last_rd [2][2];
  int          gcnt_b;

  task automatic chk(input string nm, input int d, input int p,
                     input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s dut%0d port%0d: got %h, expected %h (t=%0t)", nm, d, p, act, want, $time);
    end
  endtask

  function automatic logic [15:0] seed_of(input int p);
    logic [15:0] s;
    s = 16'hACE1 ^ 16'(p);
    if (s == 16'h0000) s = 16'h0001;
    return s;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] bitv;
    bitv = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'h0001;
    return (v >> 1) | (bitv << 15);
  endfunction

  function automatic longint offset_of(input logic [31:0] a);
    return longint'({32'd0, a}) - longint'({32'd0, BASE});
  endfunction

  function automatic bit in_rng(input int d, input logic [31:0] a);
    return (offset_of(a) >= 0) && ((offset_of(a) / 4) < longint'(DEPTH_M[d]));
  endfunction

  function automatic int mkey(input int d, input logic [31:0] a, input int b);
    return d * (1 << 20) + int'(offset_of(a) / 4) * 4 + b;
  endfunction

  function automatic bit exp_gnt(input int d, input int p);
    if (rst || !req[p]) return 1'b0;
    if (stall_en && (int'(lfsr_m[d][p] & 16'h00FF) < THR_M[d])) return 1'b0;
    return 1'b1;
  endfunction

  // Model: the effect of each clock edge on both instances
  always @(posedge clk) begin
    edges = edges + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        err_m[d] = 1'b0;
        for (int p = 0; p < 2; p++) begin
          lfsr_m[d][p] = seed_of(p);
          txn_m[d][p]  = 16'h0;
          due_q[d][p].delete();
          dat_q[d][p].delete();
          kn_q[d][p].delete();
        end
      end else begin
        for (int p = 0; p < 2; p++) g_m[p] = exp_gnt(d, p);
        for (int p = 0; p < 2; p++) begin
          if (g_m[p]) begin
            txn_m[d][p] = txn_m[d][p] + 16'h1;
            if (!in_rng(d, add[p])) err_m[d] = 1'b1;
            rdat_m = 32'h0;
            rkn_m  = 1'b1;
            if (wen[p] && !in_rng(d, add[p])) begin
              rdat_m = ERRD;
            end else if (wen[p]) begin
              for (int b = 0; b < 4; b++) begin
                if (mem_m.exists(mkey(d, add[p], b))) rdat_m[8*b +: 8] = mem_m[mkey(d, add[p], b)];
                else rkn_m = 1'b0;
              end
            end
            due_q[d][p].push_back(edges + LAT_M[d] - 1);
            dat_q[d][p].push_back(rdat_m);
            kn_q[d][p].push_back(rkn_m);
          end
        end
        for (int p = 1; p >= 0; p--) begin
          if (g_m[p] && !wen[p] && in_rng(d, add[p])) begin
            for (int b = 0; b < 4; b++)
              if (be[p][b]) mem_m[mkey(d, add[p], b)] = wdata[p][8*b +: 8];
          end
        end
        for (int p = 0; p < 2; p++) lfsr_m[d][p] = lfsr_next(lfsr_m[d][p]);
      end
    end
  end

  // Compare: every output of both instances against the model, mid-cycle
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        chk("gnt", d, p, 32'(gnt_w[d][p]), 32'(exp_gnt(d, p)));
        cmp_ev = 1'b0; cmp_ek = 1'b1; cmp_ed = 32'h0;
        if (due_q[d][p].size() > 0 && due_q[d][p][0] == edges) begin
          cmp_ev = 1'b1;
          cmp_ed = dat_q[d][p].pop_front();
          cmp_ek = kn_q[d][p].pop_front();
          void'(due_q[d][p].pop_front());
        end
        chk("r_valid", d, p, 32'(rv_w[d][p]), 32'(cmp_ev));
        if (cmp_ek) chk("r_data", d, p, rd_w[d][p], cmp_ed);
        chk("txn_cnt", d, p, 32'(txn_w[d][p]), 32'(txn_m[d][p]));
        if (rv_w[d][p]) begin
          rv_cnt[d][p]++;
          last_rd[d][p] = rd_w[d][p];
        end
      end
      chk("err", d, 0, 32'(err_w[d]), 32'(err_m[d]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    req = '0; wen = '0; add = '0; be = '0; wdata = '0;
  endtask

  task automatic op(input int p, input bit is_wr, input logic [31:0] a,
                    input logic [31:0] dat, input logic [3:0] b);
    req[p] = 1'b1; wen[p] = ~is_wr; add[p] = a; wdata[p] = dat; be[p] = b;
  endtask

  task automatic idle_n(input int n);
    set_idle();
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; stall_en = 1'b0;
    set_idle();
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_err", 0, 0, 32'(err_w[0]), 32'h0);
    chk("reset_txn", 0, 0, 32'(txn_w[0][0]), 32'h0);
    chk("reset_rv",  1, 0, 32'(rv_w[1]), 32'h0);

    // Basic write then read-back
    op(0, 1'b1, BASE + 32'h10, 32'h12345678, 4'hF); tick();
    set_idle(); op(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF); tick();
    idle_n(5);
    chk("readback", 0, 0, last_rd[0][0], 32'h12345678);
    chk("readback", 1, 0, last_rd[1][0], 32'h12345678);
    chk("txn_two", 0, 0, 32'(txn_w[0][0]), 32'h2);

    // Partial byte enables (bytes 0 and 2)
    op(0, 1'b1, BASE + 32'h20, 32'h11223344, 4'hF); tick();
    set_idle(); op(0, 1'b1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101); tick();
    set_idle(); op(0, 1'b0, BASE + 32'h20, 32'h0, 4'hF); tick();
    idle_n(5);
    chk("byte_en", 0, 0, last_rd[0][0], 32'h11BB33DD);

    // Same-word write conflict: lower port wins
    op(0, 1'b1, BASE + 32'h30, 32'hFFFF0000, 4'hF);
    op(1, 1'b1, BASE + 32'h30, 32'h0000FFFF, 4'hF); tick();
    set_idle(); op(0, 1'b0, BASE + 32'h30, 32'h0, 4'hF); tick();
    idle_n(5);
    chk("conflict", 0, 0, last_rd[0][0], 32'hFFFF0000);
    op(0, 1'b1, BASE + 32'h30, 32'h55555555, 4'hF);
    op(1, 1'b0, BASE + 32'h30, 32'h0, 4'hF); tick();
    idle_n(5);
    chk("read_old", 1, 1, last_rd[1][1], 32'hFFFF0000);
    op(1, 1'b0, BASE + 32'h30, 32'h0, 4'hF); tick();
    idle_n(5);
    chk("read_new", 0, 1, last_rd[0][1], 32'h55555555);

    // Out-of-range below base and just past the top of instance A
    chk("err_before", 0, 0, 32'(err_w[0]), 32'h0);
    op(0, 1'b0, 32'h1BFFFFFC, 32'h0, 4'hF);
    op(1, 1'b0, BASE + 32'd4096, 32'h0, 4'hF); tick();
    set_idle();
    chk("err_next", 0, 0, 32'(err_w[0]), 32'h1);
    idle_n(5);
    chk("oor_low",  0, 0, last_rd[0][0], ERRD);
    chk("oor_high", 0, 1, last_rd[0][1], ERRD);
    chk("err_held", 0, 0, 32'(err_w[0]), 32'h1);

    // LFSR stalls with a request held for 200 cycles
    rst = 1'b1; repeat (2) tick();
    rst = 1'b0; stall_en = 1'b1;
    op(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF);
    #1;
    chk("stall_c0", 0, 0, 32'(gnt_w[0][0]), 32'h1);
    gcnt_b = 0;
    for (int i = 0; i < 200; i++) begin
      if (gnt_w[1][0]) gcnt_b++;
      if (i == 1) chk("stall_c1", 0, 0, 32'(gnt_w[0][0]), 32'h0);
      tick();
    end
    chk("thr0_gnt", 1, 0, 32'(gcnt_b), 32'd200);
    idle_n(5);

    // Back-to-back reads interrupted by reset
    stall_en = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0;
    rv_cnt[0][0] = 0; rv_cnt[1][0] = 0;
    op(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF);
    repeat (6) tick();
    rst = 1'b1; set_idle();
    repeat (2) tick();
    chk("burst_rsp", 0, 0, 32'(rv_cnt[0][0]), 32'd6);
    chk("burst_rsp", 1, 0, 32'(rv_cnt[1][0]), 32'd4);
    rst = 1'b0; stall_en = 1'b1;
    op(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF);
    #1;
    chk("reseed_c0", 0, 0, 32'(gnt_w[0][0]), 32'h1);
    tick();
    chk("reseed_c1", 0, 0, 32'(gnt_w[0][0]), 32'h0);
    idle_n(4);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) stall_en = ~stall_en;
      for (int p = 0; p < 2; p++) begin
        req[p]   = ($urandom_range(0, 3) != 0);
        wen[p]   = 1'($urandom_range(0, 1));
        be[p]    = 4'($urandom);
        wdata[p] = $urandom;
        case ($urandom_range(0, 9))
          0:       add[p] = BASE - 32'd4;
          1:       add[p] = BASE + 32'd1024;
          2:       add[p] = 32'h0;
          3:       add[p] = BASE + 32'd4096;
          default: add[p] = BASE + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
        endcase
      end
      tick();
    end
    rst = 1'b1; set_idle();
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
